hub75_rx: RTL and testbench

//  Panel-side receiver for the HUB75 interface emitted by the display controller.

---
 rtl/hub75_rx.sv | 185 ++++++++++++++++++
 tb/tb_hub75_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_rx
//  Description : HUB75 panel-side receiver. Captures shifted column bursts,
//                drains them into a bit-plane framebuffer on latch, and
//                measures blank-low on-time per displayed plane.
//  Revision    : 1.0  initial release
// ============================================================================
module hub75_rx #(
  parameter int COLS   = 64,
  parameter int ROWW   = 4,
  parameter int PLANES = 4,
  parameter int ONW    = 12,
  localparam int CW    = $clog2(COLS),
  localparam int PW    = $clog2(PLANES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sclk,
  input  logic               latch,
  input  logic               blank,
  input  logic [2:0]         din_top,
  input  logic [2:0]         din_btm,
  input  logic [ROWW-1:0]    row_sel,
  output logic               wr_en,
  output logic [ROWW+CW-1:0] wr_addr,
  output logic [PW-1:0]      wr_plane,
  output logic [2:0]         wr_top,
  output logic [2:0]         wr_btm,
  output logic               on_valid,
  output logic [ONW-1:0]     on_cycles,
  output logic [PW-1:0]      on_plane,
  output logic               overrun,
  output logic               len_err
);

  localparam logic [CW:0]   CNT_FULL = (CW+1)'(COLS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state, state_nx;
  logic            sclk_q, latch_q, blank_q;
  logic            sclk_rise, latch_rise, blank_rise, blank_fall;
  logic            latch_take;
  logic [2:0]      top_sr   [COLS];
  logic [2:0]      btm_sr   [COLS];
  logic [2:0]      top_hold [COLS];
  logic [2:0]      btm_hold [COLS];
  logic [2:0]      top_s    [COLS];
  logic [2:0]      btm_s    [COLS];
  logic [CW:0]     shift_cnt, cnt_s;
  logic [ROWW-1:0] burst_row, last_row, cap_row, row_s;
  logic [PW-1:0]   plane_cnt, cap_plane, plane_s;
  logic [CW-1:0]   col;
  logic [ONW-1:0]  on_cnt;

  assign sclk_rise  = sclk & ~sclk_q;
  assign latch_rise = latch & ~latch_q;
  assign blank_rise = blank & ~blank_q;
  assign blank_fall = ~blank & blank_q;
  assign latch_take = latch_rise && (state == IDLE);

  // Post-shift view of the burst state, so a latch in the same cycle as a
  // shift captures the freshly shifted bit.
  always_comb begin
    top_s   = top_sr;
    btm_s   = btm_sr;
    cnt_s   = shift_cnt;
    row_s   = burst_row;
    plane_s = plane_cnt;
    if (sclk_rise) begin
      for (int i = 0; i < COLS - 1; i++) begin
        top_s[i] = top_sr[i+1];
        btm_s[i] = btm_sr[i+1];
      end
      top_s[COLS-1] = din_top;
      btm_s[COLS-1] = din_btm;
      if (shift_cnt != CNT_FULL) cnt_s = shift_cnt + 1'b1;
      if (shift_cnt == '0) begin
        row_s = row_sel;
        if (row_sel != last_row) plane_s = '0;
      end
    end
  end

  // Edge-detect history, shift registers, burst counters and latch capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q    <= 1'b1;
      latch_q   <= 1'b1;
      blank_q   <= 1'b1;
      top_sr    <= '{default: '0};
      btm_sr    <= '{default: '0};
      top_hold  <= '{default: '0};
      btm_hold  <= '{default: '0};
      shift_cnt <= '0;
      burst_row <= '0;
      last_row  <= '0;
      cap_row   <= '0;
      plane_cnt <= '0;
      cap_plane <= '0;
      len_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sclk_q    <= sclk;
      latch_q   <= latch;
      blank_q   <= blank;
      top_sr    <= top_s;
      btm_sr    <= btm_s;
      burst_row <= row_s;
      len_err   <= latch_take && (cnt_s != CNT_FULL);
      overrun   <= latch_rise && (state == DRAIN);
      if (latch_take) begin
        top_hold  <= top_s;
        btm_hold  <= btm_s;
        cap_row   <= row_s;
        cap_plane <= plane_s;
        last_row  <= row_s;
        plane_cnt <= plane_s + 1'b1;
        shift_cnt <= '0;
      end else begin
        plane_cnt <= plane_s;
        shift_cnt <= cnt_s;
      end
    end
  end

  // Drain state register and column pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
    end else begin
      state <= state_nx;
      if (latch_take)           col <= '0;
      else if (state == DRAIN)  col <= col + 1'b1;
    end
  end

  // Next-state: one full column sweep per accepted latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (latch_rise) state_nx = DRAIN;
      DRAIN:   if (col == COL_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Blank-low on-time measurement; the fall cycle itself counts as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_cnt    <= '0;
      on_valid  <= 1'b0;
      on_cycles <= '0;
      on_plane  <= '0;
    end else begin
      on_valid <= blank_rise;
      if (blank_fall)                    on_cnt <= ONW'(1);
      else if (!blank && on_cnt != '1)   on_cnt <= on_cnt + 1'b1;
      if (blank_rise) begin
        on_cycles <= on_cnt;
        on_plane  <= cap_plane;
      end
    end
  end

  // Framebuffer write port, zeroed outside a drain.
  always_comb begin
    wr_en    = (state == DRAIN);
    wr_addr  = '0;
    wr_plane = '0;
    wr_top   = '0;
    wr_btm   = '0;
    if (wr_en) begin
      wr_addr  = {cap_row, col};
      wr_plane = cap_plane;
      wr_top   = top_hold[col];
      wr_btm   = btm_hold[col];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_rx
//  Description : Self-checking bench for hub75_rx with a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hub75_rx;

  localparam int COLS = 64;
  localparam int ONMAX = 4095;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0, latch = 1'b0, blank = 1'b1;
  logic [2:0] din_top = '0, din_btm = '0;
  logic [3:0] row_sel = '0;
  logic       wr_en, on_valid, overrun, len_err;
  logic [9:0] wr_addr;
  logic [1:0] wr_plane, on_plane;
  logic [2:0] wr_top, wr_btm;
  logic [11:0] on_cycles;

  hub75_rx dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .latch(latch), .blank(blank),
    .din_top(din_top), .din_btm(din_btm), .row_sel(row_sel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_plane(wr_plane),
    .wr_top(wr_top), .wr_btm(wr_btm), .on_valid(on_valid),
    .on_cycles(on_cycles), .on_plane(on_plane), .overrun(overrun),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [9:0] addr;
    logic [1:0] pl;
    logic [2:0] t;
    logic [2:0] b;
  } wr_t;

  logic [5:0] hist[$];   // last COLS shifted pixels, oldest = column 0
  wr_t        wq[$];
  int  scnt, brow, lrow, pcnt, cplane, oncnt;
  logic m_sclk_q, m_latch_q, m_blank_q;
  logic e_wr_en, e_onv, e_len, e_ovr;
  wr_t  e_wr;
  int   e_onc, e_onp;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < COLS; i++) hist.push_back(6'd0);
    wq.delete();
    scnt = 0; brow = 0; lrow = 0; pcnt = 0; cplane = 0; oncnt = 0;
    m_sclk_q = 1; m_latch_q = 1; m_blank_q = 1;
    e_wr_en = 0; e_wr = '0; e_onv = 0; e_len = 0; e_ovr = 0; e_onc = 0; e_onp = 0;
  endtask

  task automatic model_step();
    logic rs, rl, rb, fb, busy;
    logic [5:0] px;
    logic [5:0] cc;
    rs = sclk & ~m_sclk_q;
    rl = latch & ~m_latch_q;
    rb = blank & ~m_blank_q;
    fb = ~blank & m_blank_q;
    m_sclk_q = sclk; m_latch_q = latch; m_blank_q = blank;
    busy = e_wr_en;
    e_onv = 0; e_len = 0; e_ovr = 0;
    if (rs) begin
      if (scnt == 0) begin
        brow = int'(row_sel);
        if (brow != lrow) pcnt = 0;
      end
      hist.push_back({din_btm, din_top});
      hist.delete(0);
      if (scnt < COLS) scnt++;
    end
    if (fb) oncnt = 1;
    else if (!blank && oncnt < ONMAX) oncnt++;
    if (rb) begin
      e_onv = 1; e_onc = oncnt; e_onp = cplane;
    end
    if (rl) begin
      if (busy) e_ovr = 1;
      else begin
        e_len = (scnt != COLS);
        for (int c = 0; c < COLS; c++) begin
          px = hist[c];
          cc = 6'(c);
          wq.push_back({4'(brow), cc, 2'(pcnt), px[2:0], px[5:3]});
        end
        cplane = pcnt;
        lrow = brow;
        pcnt = (pcnt + 1) % 4;
        scnt = 0;
      end
    end
    if (wq.size() > 0) begin
      e_wr = wq.pop_front(); e_wr_en = 1;
    end else begin
      e_wr = '0; e_wr_en = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- compare + logging process ----------------
  logic [2:0] log_top [COLS];
  logic [2:0] log_btm [COLS];
  logic [9:0] log_addr [COLS];
  logic [1:0] log_pl [COLS];
  int wcount = 0, len_cnt = 0, ovr_cnt = 0;
  int lat_pl[$], lat_row[$], onq_c[$], onq_p[$];

  initial forever begin
    @(negedge clk);
    chk("wr_en", wr_en, e_wr_en);
    if (e_wr_en) begin
      chk("wr_addr", wr_addr, e_wr.addr);
      chk("wr_plane", wr_plane, e_wr.pl);
      chk("wr_top", wr_top, e_wr.t);
      chk("wr_btm", wr_btm, e_wr.b);
    end
    chk("on_valid", on_valid, e_onv);
    if (e_onv) begin
      chk("on_cycles", on_cycles, e_onc);
      chk("on_plane", on_plane, e_onp);
    end
    chk("len_err", len_err, e_len);
    chk("overrun", overrun, e_ovr);
    if (wr_en) begin
      log_top[wr_addr[5:0]]  = wr_top;
      log_btm[wr_addr[5:0]]  = wr_btm;
      log_addr[wr_addr[5:0]] = wr_addr;
      log_pl[wr_addr[5:0]]   = wr_plane;
      wcount++;
      if (wr_addr[5:0] == 6'd0) begin
        lat_pl.push_back(int'(wr_plane));
        lat_row.push_back(int'(wr_addr[9:6]));
      end
    end
    if (on_valid) begin
      onq_c.push_back(int'(on_cycles));
      onq_p.push_back(int'(on_plane));
    end
    if (len_err) len_cnt++;
    if (overrun) ovr_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic burst(input int n, input int r, input bit pat, input bit chg_row);
    logic [5:0] cv;
    for (int c = 0; c < n; c++) begin
      row_sel = (c > 0 && chg_row) ? 4'(r + 1) : 4'(r);
      cv = 6'(c);
      if (pat) begin
        din_top = cv[2:0]; din_btm = ~cv[2:0];
      end else begin
        din_top = 3'($urandom); din_btm = 3'($urandom);
      end
      sclk = 1; tick(1);
      sclk = 0; tick(1);
    end
  endtask

  task automatic pulse_latch();
    latch = 1; tick(1);
    latch = 0; tick(1);
  endtask

  task automatic blank_low(input int n);
    blank = 0; tick(n);
    blank = 1;
  endtask

  int lens[4] = '{256, 256, 512, 1024};

  initial begin
    tick(3);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_on_valid", on_valid, 0);
    chk("rst_on_cycles", on_cycles, 0);
    chk("rst_len_err", len_err, 0);
    rst_n = 1;
    tick(3);

    // Patterned burst on row 5
    wcount = 0; len_cnt = 0;
    burst(COLS, 5, 1'b1, 1'b0);
    pulse_latch();
    tick(70);
    chk("pat_wcount", wcount, 64);
    chk("pat_addr63", log_addr[63], {4'd5, 6'd63});
    chk("pat_top10", log_top[10], 2);
    chk("pat_btm10", log_btm[10], 5);
    chk("pat_btm0", log_btm[0], 7);
    chk("pat_plane", log_pl[0], 0);
    chk("pat_len_err", len_cnt, 0);

    // Full driver sequence: rows 0..1, planes 0..3, timed blank
    lat_pl.delete(); lat_row.delete(); onq_c.delete(); onq_p.delete();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) begin
        burst(COLS, r, 1'b0, 1'b1);
        pulse_latch();
        tick(70);
        if (r == 0) blank_low(lens[p]);
        else blank_low(int'($urandom_range(5, 40)));
        tick(3);
      end
    end
    chk("seq_latches", lat_pl.size(), 8);
    chk("seq_onq", onq_c.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("seq_plane", lat_pl[i], i % 4);
      chk("seq_row", lat_row[i], i / 4);
    end
    for (int i = 0; i < 4; i++) begin
      chk("on_len", onq_c[i], lens[i]);
      chk("on_pl", onq_p[i], i);
    end

    // Short burst then latch during drain
    len_cnt = 0; ovr_cnt = 0;
    burst(63, 2, 1'b0, 1'b0);
    pulse_latch();
    tick(8);
    pulse_latch();
    tick(80);
    chk("short_len_err", len_cnt, 1);
    chk("drain_overrun", ovr_cnt, 1);

    // Saturating on-time
    onq_c.delete();
    blank_low(5000);
    tick(3);
    chk("sat_cnt", onq_c.size(), 1);
    chk("sat_val", onq_c[0], ONMAX);

    // Reset in the middle of a drain
    burst(COLS, 3, 1'b0, 1'b0);
    pulse_latch();
    tick(20);
    chk("mid_wr_en", wr_en, 1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_mid_wr_en", wr_en, 0);
    tick(3);
    rst_n = 1;
    tick(3);

    // Random traffic against the model
    repeat (4000) begin
      sclk  = 1'($urandom_range(0, 1));
      latch = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) blank = ~blank;
      din_top = 3'($urandom);
      din_btm = 3'($urandom);
      if ($urandom_range(0, 99) == 0) row_sel = 4'($urandom);
      tick(1);
    end
    latch = 0; blank = 1; sclk = 0;
    tick(80);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
